cdb_arbiter: RTL
================

# cdb_arbiter

Arbitrates completed results from the functional units (ALU, load, multiply/divide) onto the single common data bus. Each requester gets a one-entry holding slot, so a unit can drop its result and move on. One holding slot is granted per cycle and broadcast as a registered `cdb_t` to the ROB, the reservation stations and the physical register file. Branch/JALR results take priority over ordinary results, with a starvation guard. The block sits between the functional-unit outputs and the CDB consumers.

## Interface
- `NUM_REQ`, default 4: number of requesting units; must be ≥2.
- `MAX_WAIT`, default 8: cycles a held entry may wait before it is promoted to urgent; must be ≥1.
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous mispredict flush.
- `req_valid`  in  NUM_REQ: per-unit result valid.
- `req_data`  in  cdb_t [NUM_REQ]: per-unit result; its `cdb_valid` field is ignored.
- `req_ready`  out  NUM_REQ: the slot can accept a result this cycle.
- `cdb_out`  out  cdb_t: registered CDB broadcast, qualified by `cdb_out.cdb_valid`.
- `grant_idx`  out  $clog2(NUM_REQ): index of the requester broadcast in `cdb_out`. Valid only when `cdb_out.cdb_valid` is high.

## Operation
- **Per-slot state:** `hold_v[i]`, `hold_d[i]`, and `wait_cnt[i]` of width $clog2(MAX_WAIT+1). The block also holds `rr_ptr` of width $clog2(NUM_REQ).
- **Ready:** `req_ready[i] = !rst && !flush && (!hold_v[i] || grant[i])`.
  - This is computed from registered state plus the grant only; there is no combinational path from `req_valid` to `req_ready`.
- **Accept:** when `req_valid[i] && req_ready[i]`, set `hold_v[i]`, load `hold_d[i]` and clear `wait_cnt[i]`. Otherwise, if the slot is granted, clear `hold_v[i]`.
- **Classes:** each held entry falls into one of three classes.
  - Class 0 (urgent): `wait_cnt[i] == MAX_WAIT`.
  - Class 1: `branch_flag || jalr_flag`.
  - Class 2: all other entries.
- **Grant:**
  - The winner comes from the lowest-numbered non-empty class.
  - Within that class, the scan is round-robin: start at `rr_ptr`, ascending, wrapping from NUM_REQ-1 to 0.
  - At most one grant per cycle.
- **On a grant to index g:**
  - Next cycle, `cdb_out = hold_d[g]` with `cdb_valid = 1`, and `grant_idx = g`.
  - `rr_ptr` becomes `g+1`, or 0 when g = NUM_REQ-1.
- **No grant:** next cycle `cdb_out.cdb_valid = 0`; the other `cdb_out` fields keep their previous values. `rr_ptr` is unchanged.
- **Wait counters:** every cycle that `hold_v[i]` is set and slot i is not granted, `wait_cnt[i]` increments, saturating at MAX_WAIT.
- **Flush:**
  - Next cycle: all `hold_v` = 0, all `wait_cnt` = 0, `cdb_out.cdb_valid` = 0.
  - Grants computed in the flush cycle are discarded.
  - Inputs presented in the flush cycle are not accepted (`req_ready` is 0).
  - `rr_ptr` is preserved.
- **Reset:**
  - `hold_v` = 0, `wait_cnt` = 0, `rr_ptr` = 0.
  - `cdb_out` all fields 0, `grant_idx` = 0.
  - `req_ready` = 0 while `rst` is high; all ones in the first cycle after release.

## Timing
- **Minimum latency:** accept in cycle N, held in N+1, granted in N+1, on the CDB in N+2.
- **Back-to-back on one requester:** a slot granted in cycle N may accept a new result in cycle N; that result can appear on the CDB at N+2 at the earliest. A single unit alone therefore sustains 1 result per cycle.
- **Throughput:** one broadcast per cycle whenever any slot is held.
- **Worst-case wait:**
  - A class-2 entry reaches urgent after MAX_WAIT cycles.
  - Once urgent, it is granted within NUM_REQ-1 further cycles, since urgent entries are served round-robin.
  - Resulting bound: MAX_WAIT + NUM_REQ cycles.
- **Simultaneous events:**
  - Accept and grant on the same slot in one cycle: the new data replaces the old; the old data is broadcast.
  - Flush overrides accept and grant.
  - Reset overrides everything, asynchronously.

## Test plan
- **Reset values:** assert `rst` mid-traffic with 3 slots held → immediately `cdb_out.cdb_valid` = 0 and `req_ready` = 0000. After release, `req_ready` = 1111, and the first grant after a single request on unit 2 has `grant_idx` = 2.
- **Round-robin:** `rr_ptr` = 0; all 4 units present class-2 results in the same cycle, with `result` = 0xA0..0xA3 → broadcasts on 4 consecutive cycles in order 0xA0, 0xA1, 0xA2, 0xA3; `rr_ptr` ends at 0.
- **Branch priority:** unit 0 holds class 2, unit 3 holds a result with `branch_flag` = 1, `rr_ptr` = 0 → unit 3 is broadcast first, unit 0 the next cycle.
- **Starvation guard:** MAX_WAIT = 8; unit 0 holds class 2 while units 1–3 inject branch results every cycle → unit 0 is broadcast no later than 8 + 4 = 12 cycles after it was accepted.
- **Flush:** 3 slots held, pulse `flush` for 1 cycle → the next cycle has `cdb_out.cdb_valid` = 0, and a request presented in the flush cycle is never broadcast. A request in the cycle after flush is broadcast 2 cycles later.
- **Streaming:** unit 1 alone asserts `req_valid` for 10 consecutive cycles with `result` = 1..10 → `req_ready[1]` stays 1 throughout, and `cdb_out` shows 1..10 on consecutive cycles starting 2 cycles after the first request.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, one
// registered broadcast per cycle, with urgent > branch/jalr > normal priority
// and round-robin order inside each class.

package cdb_pkg;
  typedef struct packed {
    logic        cdb_valid;
    logic [5:0]  rob_tag;
    logic [6:0]  pdst;
    logic [31:0] result;
    logic        branch_flag;
    logic        jalr_flag;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  cdb_t                       req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output cdb_t                       cdb_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [NUM_REQ-1:0] hold_v_q, hold_v_d;
  cdb_t               hold_d_q [NUM_REQ];
  cdb_t               hold_d_d [NUM_REQ];
  logic [WW-1:0]      wait_cnt_q [NUM_REQ];
  logic [WW-1:0]      wait_cnt_d [NUM_REQ];
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  cdb_t               cdb_out_q, cdb_out_d;
  logic [IW-1:0]      grant_idx_q, grant_idx_d;

  logic [NUM_REQ-1:0] urg_mask, br_mask, norm_mask, sel_mask;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      scan_idx;
  logic               grant_any;

  // Classify held slots and pick one winner from the highest-priority class,
  // scanning round-robin from rr_ptr.
  always_comb begin
    urg_mask  = '0;
    br_mask   = '0;
    norm_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      urg_mask[i]  = hold_v_q[i] && (wait_cnt_q[i] == WW'(MAX_WAIT));
      br_mask[i]   = hold_v_q[i] && (hold_d_q[i].branch_flag || hold_d_q[i].jalr_flag);
      norm_mask[i] = hold_v_q[i];
    end
    if (|urg_mask)     sel_mask = urg_mask;
    else if (|br_mask) sel_mask = br_mask;
    else               sel_mask = norm_mask;

    grant_any = 1'b0;
    gidx      = '0;
    scan_idx  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = IW'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!grant_any && sel_mask[scan_idx]) begin
        grant_any = 1'b1;
        gidx      = scan_idx;
      end
    end
    grant = '0;
    if (grant_any) grant[gidx] = 1'b1;
  end

  // Ready depends only on registered state and the grant, never on req_valid.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && !flush && (!hold_v_q[i] || grant[i]);
    end
  end

  // Slot update, wait counters, broadcast register and round-robin pointer.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_d_d    = hold_d_q;
    wait_cnt_d  = wait_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    cdb_out_d   = cdb_out_q;
    cdb_out_d.cdb_valid = 1'b0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        hold_v_d[i]   = 1'b1;
        hold_d_d[i]   = req_data[i];
        wait_cnt_d[i] = '0;
      end else if (grant[i]) begin
        hold_v_d[i]   = 1'b0;
        wait_cnt_d[i] = '0;
      end else if (hold_v_q[i] && (wait_cnt_q[i] != WW'(MAX_WAIT))) begin
        wait_cnt_d[i] = wait_cnt_q[i] + WW'(1);
      end
    end

    if (grant_any) begin
      cdb_out_d           = hold_d_q[gidx];
      cdb_out_d.cdb_valid = 1'b1;
      grant_idx_d         = gidx;
      rr_ptr_d            = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
    end

    // Flush discards this cycle's grant entirely, so broadcast fields,
    // grant_idx and rr_ptr fall back to their held values.
    if (flush) begin
      hold_v_d            = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt_d[i] = '0;
      cdb_out_d           = cdb_out_q;
      cdb_out_d.cdb_valid = 1'b0;
      grant_idx_d         = grant_idx_q;
      rr_ptr_d            = rr_ptr_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q    <= '0;
      rr_ptr_q    <= '0;
      cdb_out_q   <= '0;
      grant_idx_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hold_d_q[i]   <= '0;
        wait_cnt_q[i] <= '0;
      end
    end else begin
      hold_v_q    <= hold_v_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_out_q   <= cdb_out_d;
      grant_idx_q <= grant_idx_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hold_d_q[i]   <= hold_d_d[i];
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign cdb_out   = cdb_out_q;
  assign grant_idx = grant_idx_q;

endmodule
